// File: rtl/bmp_pkg.sv
// Shared types, constants and size helpers for the BMP stream writer.
package bmp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PIXEL,
        PAD,
        DONE
    } state_t;

    localparam int unsigned BMP_HDR_BYTES = 54;
    localparam int unsigned PIX_BYTES     = 3;

    // Zero bytes appended to each row so the row length is a multiple of 4.
    function automatic int unsigned row_pad(input int unsigned w);
        return (4 - ((PIX_BYTES * w) % 4)) % 4;
    endfunction

    // Pixel array size in bytes, padding included.
    function automatic int unsigned img_size(input int unsigned w, input int unsigned h,
                                             input int unsigned pad);
        return h * (PIX_BYTES * w + pad);
    endfunction

    // Byte idx of a little-endian 32-bit field.
    function automatic logic [7:0] le_byte(input logic [31:0] val, input logic [1:0] idx);
        return val[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/bmp_stream_writer_if.sv
// Pixel-beat input stream and file-byte output stream of the BMP writer.
interface bmp_stream_writer_if #(
    parameter int unsigned PIX_PER_BEAT = 2
);
    localparam int unsigned DATA_W = 24 * PIX_PER_BEAT;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/bmp_header_rom.sv
// Constant 54-byte BMP header, one byte selected by index.
module bmp_header_rom
    import bmp_pkg::*;
#(
    parameter int unsigned WIDTH    = 768,
    parameter int unsigned HEIGHT   = 512,
    parameter int unsigned TOP_DOWN = 0
) (
    input  logic [5:0] hdr_idx,
    output logic [7:0] hdr_byte_c
);

    localparam int unsigned PAD_BYTES = row_pad(WIDTH);
    localparam logic [31:0] IMG       = 32'(img_size(WIDTH, HEIGHT, PAD_BYTES));
    localparam logic [31:0] FILE_SZ   = IMG + 32'(BMP_HDR_BYTES);
    localparam logic [31:0] HGT       = (TOP_DOWN != 0) ? (32'd0 - 32'(HEIGHT)) : 32'(HEIGHT);

    // Header byte lookup; unlisted offsets are zero.
    always_comb begin
        hdr_byte_c = 8'h00;
        case (hdr_idx)
            6'd0:                      hdr_byte_c = 8'h42;
            6'd1:                      hdr_byte_c = 8'h4D;
            6'd2, 6'd3, 6'd4, 6'd5:    hdr_byte_c = le_byte(FILE_SZ, 2'(hdr_idx - 6'd2));
            6'd10, 6'd11, 6'd12, 6'd13: hdr_byte_c = le_byte(32'(BMP_HDR_BYTES), 2'(hdr_idx - 6'd10));
            6'd14, 6'd15, 6'd16, 6'd17: hdr_byte_c = le_byte(32'd40, 2'(hdr_idx - 6'd14));
            6'd18, 6'd19, 6'd20, 6'd21: hdr_byte_c = le_byte(32'(WIDTH), 2'(hdr_idx - 6'd18));
            6'd22, 6'd23, 6'd24, 6'd25: hdr_byte_c = le_byte(HGT, 2'(hdr_idx - 6'd22));
            6'd26:                     hdr_byte_c = 8'd1;
            6'd28:                     hdr_byte_c = 8'd24;
            6'd34, 6'd35, 6'd36, 6'd37: hdr_byte_c = le_byte(IMG, 2'(hdr_idx - 6'd34));
            default:                   hdr_byte_c = 8'h00;
        endcase
    end

endmodule

// File: rtl/bmp_stream_writer.sv
// Serialises one 24-bit BMP file (header, BGR pixels, row padding) as a byte stream.
module bmp_stream_writer
    import bmp_pkg::*;
#(
    parameter int unsigned WIDTH        = 768,
    parameter int unsigned HEIGHT       = 512,
    parameter int unsigned PIX_PER_BEAT = 2,
    parameter int unsigned TOP_DOWN     = 0
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               start,
    bmp_stream_writer_if.slave bus,
    output logic               busy,
    output logic               write_done
);

    localparam int unsigned PAD_BYTES     = row_pad(WIDTH);
    localparam int unsigned BEAT_BYTES    = PIX_BYTES * PIX_PER_BEAT;
    localparam int unsigned DATA_W        = 8 * BEAT_BYTES;
    localparam int unsigned BEATS_PER_ROW = WIDTH / PIX_PER_BEAT;
    localparam int unsigned BYTE_W        = $clog2(BEAT_BYTES);
    localparam int unsigned COL_W         = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
    localparam int unsigned ROW_W         = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BEAT_BYTES - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(BEATS_PER_ROW - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(HEIGHT - 1);
    localparam logic [1:0]        PAD_LAST  = 2'((PAD_BYTES == 0) ? 0 : PAD_BYTES - 1);
    localparam logic [5:0]        HDR_LAST  = 6'(BMP_HDR_BYTES - 1);

    state_t              state_q, state_d;
    logic [5:0]          hdr_idx_q, hdr_idx_d;
    logic [BYTE_W-1:0]   byte_idx_q, byte_idx_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [1:0]          pad_q, pad_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic                buf_full_q, buf_full_d;
    logic                out_valid_q, out_valid_d;
    logic [7:0]          out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;
    logic                write_done_q, write_done_d;

    logic                out_hs;
    logic                in_hs;
    logic                in_ready_c;
    logic [7:0]          hdr_byte_c;

    bmp_header_rom #(
        .WIDTH    (WIDTH),
        .HEIGHT   (HEIGHT),
        .TOP_DOWN (TOP_DOWN)
    ) u_hdr_rom (
        .hdr_idx    (hdr_idx_d),
        .hdr_byte_c (hdr_byte_c)
    );

    // Beat buffer refills when empty or as its last byte leaves, except before a pad or after the frame.
    always_comb begin
        out_hs     = out_valid_q && bus.out_ready;
        in_ready_c = (state_q == PIXEL) &&
                     (!buf_full_q ||
                      (out_hs && (byte_idx_q == BYTE_LAST) &&
                       !((col_q == COL_LAST) && ((PAD_BYTES != 0) || (row_q == ROW_LAST)))));
        in_hs      = bus.in_valid && in_ready_c;
    end

    // Next state, counters and beat buffer.
    always_comb begin
        state_d    = state_q;
        hdr_idx_d  = hdr_idx_q;
        byte_idx_d = byte_idx_q;
        col_d      = col_q;
        row_d      = row_q;
        pad_d      = pad_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = HEADER;
                    hdr_idx_d  = '0;
                    byte_idx_d = '0;
                    col_d      = '0;
                    row_d      = '0;
                    pad_d      = '0;
                    buf_full_d = 1'b0;
                end
            end
            HEADER: begin
                if (out_hs) begin
                    if (hdr_idx_q == HDR_LAST) state_d = PIXEL;
                    else                       hdr_idx_d = hdr_idx_q + 6'd1;
                end
            end
            PIXEL: begin
                if (out_hs) begin
                    if (byte_idx_q == BYTE_LAST) begin
                        byte_idx_d = '0;
                        buf_full_d = 1'b0;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (PAD_BYTES != 0) begin
                                state_d = PAD;
                                pad_d   = '0;
                            end else if (row_q == ROW_LAST) begin
                                state_d = DONE;
                            end else begin
                                row_d = row_q + ROW_W'(1);
                            end
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + BYTE_W'(1);
                    end
                end
                if (in_hs) begin
                    buf_d      = bus.in_data;
                    buf_full_d = 1'b1;
                end
            end
            PAD: begin
                if (out_hs) begin
                    if (pad_q == PAD_LAST) begin
                        pad_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d = DONE;
                        end else begin
                            state_d = PIXEL;
                            row_d   = row_q + ROW_W'(1);
                        end
                    end else begin
                        pad_d = pad_q + 2'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs describe the byte at the next stream position.
    always_comb begin
        out_valid_d  = 1'b0;
        out_data_d   = 8'h00;
        out_last_d   = 1'b0;
        busy_d       = 1'b0;
        write_done_d = 1'b0;
        case (state_d)
            HEADER: begin
                busy_d      = 1'b1;
                out_valid_d = 1'b1;
                out_data_d  = hdr_byte_c;
            end
            PIXEL: begin
                busy_d      = 1'b1;
                out_valid_d = buf_full_d;
                out_data_d  = buf_full_d ? buf_d[{byte_idx_d, 3'b000} +: 8] : 8'h00;
                out_last_d  = (PAD_BYTES == 0) && buf_full_d && (byte_idx_d == BYTE_LAST) &&
                              (col_d == COL_LAST) && (row_d == ROW_LAST);
            end
            PAD: begin
                busy_d      = 1'b1;
                out_valid_d = 1'b1;
                out_last_d  = (pad_d == PAD_LAST) && (row_d == ROW_LAST);
            end
            DONE:    write_done_d = 1'b1;
            default: ;
        endcase
    end

    // State and output registers.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q      <= IDLE;
            hdr_idx_q    <= '0;
            byte_idx_q   <= '0;
            col_q        <= '0;
            row_q        <= '0;
            pad_q        <= '0;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            write_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_idx_q    <= hdr_idx_d;
            byte_idx_q   <= byte_idx_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pad_q        <= pad_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            write_done_q <= write_done_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign busy          = busy_q;
    assign write_done    = write_done_q;

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Bench for bmp_stream_writer: three parameter sets against a byte-stream reference model.
module tb_bmp_stream_writer;

    localparam int MAX_CYC = 40000;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned sel;
    logic        start_t, in_valid_t, out_ready_t;
    logic [95:0] in_data_t;

    logic        o_valid, o_last, o_in_ready, o_busy, o_done;
    logic [7:0]  o_data;
    logic        busy0, busy1, busy2, done0, done1, done2;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  got [64];

    always #5 clk = ~clk;

    bmp_stream_writer_if #(.PIX_PER_BEAT(2)) if0 ();
    bmp_stream_writer_if #(.PIX_PER_BEAT(1)) if1 ();
    bmp_stream_writer_if #(.PIX_PER_BEAT(2)) if2 ();

    assign if0.in_valid  = in_valid_t && (sel == 32'd0);
    assign if0.in_data   = in_data_t[47:0];
    assign if0.out_ready = out_ready_t && (sel == 32'd0);
    assign if1.in_valid  = in_valid_t && (sel == 32'd1);
    assign if1.in_data   = in_data_t[23:0];
    assign if1.out_ready = out_ready_t && (sel == 32'd1);
    assign if2.in_valid  = in_valid_t && (sel == 32'd2);
    assign if2.in_data   = in_data_t[47:0];
    assign if2.out_ready = out_ready_t && (sel == 32'd2);

    bmp_stream_writer #(.WIDTH(768), .HEIGHT(512), .PIX_PER_BEAT(2), .TOP_DOWN(0)) u0 (
        .HCLK(clk), .HRESET(rst_n), .start(start_t && (sel == 32'd0)),
        .bus(if0), .busy(busy0), .write_done(done0));
    bmp_stream_writer #(.WIDTH(5), .HEIGHT(2), .PIX_PER_BEAT(1), .TOP_DOWN(0)) u1 (
        .HCLK(clk), .HRESET(rst_n), .start(start_t && (sel == 32'd1)),
        .bus(if1), .busy(busy1), .write_done(done1));
    bmp_stream_writer #(.WIDTH(6), .HEIGHT(512), .PIX_PER_BEAT(2), .TOP_DOWN(1)) u2 (
        .HCLK(clk), .HRESET(rst_n), .start(start_t && (sel == 32'd2)),
        .bus(if2), .busy(busy2), .write_done(done2));

    // Observe the selected instance.
    always_comb begin
        o_valid = if0.out_valid; o_data = if0.out_data; o_last = if0.out_last;
        o_in_ready = if0.in_ready; o_busy = busy0; o_done = done0;
        if (sel == 32'd1) begin
            o_valid = if1.out_valid; o_data = if1.out_data; o_last = if1.out_last;
            o_in_ready = if1.in_ready; o_busy = busy1; o_done = done1;
        end else if (sel == 32'd2) begin
            o_valid = if2.out_valid; o_data = if2.out_data; o_last = if2.out_last;
            o_in_ready = if2.in_ready; o_busy = busy2; o_done = done2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_bytes(input string tag, input int base, input logic [63:0] vals, input int n);
        logic [63:0] v;
        v = vals;
        for (int i = 0; i < n; i++) chk(tag, 32'(got[base + i]), 32'(v[8 * (n - 1 - i) +: 8]));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_data"}, 32'(o_data), 32'd0);
        chk({tag, "_last"}, 32'(o_last), 32'd0);
        chk({tag, "_in_ready"}, 32'(o_in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
    endtask

    // Drive one frame and compare every byte with the model; stop_after>0 abandons it early.
    task automatic run_frame(input int unsigned s, input int w, input int h, input int ppb,
                             input bit td, input int stop_after, input bit directed,
                             input int start_pulse_at, input int ready_pct, input int valid_pct);
        logic [23:0] pix [$];
        logic [7:0]  expq [$];
        bit          padf [$];
        logic [31:0] wa [6];
        logic [31:0] wb [6];
        logic [95:0] beat;
        logic [7:0]  prev_data;
        int padn, fsize, rows, nbeats, beat_idx, pos, cyc;
        bit held, prev_stall, pulsed, finished;

        padn  = (4 - ((3 * w) % 4)) % 4;
        fsize = 54 + h * (3 * w + padn);
        rows  = (stop_after > 0) ? 1 : h;
        for (int i = 0; i < w * rows; i++) pix.push_back(24'($urandom));
        if (directed) begin
            pix[0] = 24'hAABBCC;
            pix[1] = 24'h112233;
        end
        wa = '{32'(fsize), 32'd0, 32'd54, 32'd40, 32'(w), 32'(td ? -h : h)};
        wb = '{32'd0, 32'(fsize - 54), 32'd0, 32'd0, 32'd0, 32'd0};
        expq.push_back(8'h42); expq.push_back(8'h4D);
        for (int k = 0; k < 6; k++) for (int b = 0; b < 4; b++) expq.push_back(wa[k][8 * b +: 8]);
        expq.push_back(8'd1); expq.push_back(8'd0); expq.push_back(8'd24); expq.push_back(8'd0);
        for (int k = 0; k < 6; k++) for (int b = 0; b < 4; b++) expq.push_back(wb[k][8 * b +: 8]);
        for (int i = 0; i < 54; i++) padf.push_back(1'b0);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < w; c++) begin
                for (int b = 0; b < 3; b++) begin
                    expq.push_back(pix[r * w + c][8 * b +: 8]);
                    padf.push_back(1'b0);
                end
            end
            for (int p = 0; p < padn; p++) begin
                expq.push_back(8'h00);
                padf.push_back(1'b1);
            end
        end
        nbeats = w * rows / ppb;

        sel = s; beat_idx = 0; pos = 0; cyc = 0;
        held = 0; prev_stall = 0; pulsed = 0; finished = 0; prev_data = 8'h00;
        @(negedge clk);
        start_t = 1'b1;
        @(negedge clk);
        while (!finished) begin
            start_t = 1'b0;
            if (start_pulse_at > 0 && !pulsed && pos >= start_pulse_at) begin
                start_t = 1'b1;
                pulsed  = 1'b1;
            end
            out_ready_t = ($urandom_range(99) < 32'(ready_pct));
            if (beat_idx < nbeats) begin
                if (!held) begin
                    in_valid_t = ($urandom_range(99) < 32'(valid_pct));
                    if (in_valid_t) begin
                        beat = '0;
                        for (int k = 0; k < ppb; k++) beat[24 * k +: 24] = pix[beat_idx * ppb + k];
                        in_data_t = beat;
                        held = 1'b1;
                    end
                end
            end else begin
                in_valid_t = 1'b1;
                in_data_t  = {3{32'hDEAD_BEEF}};
            end
            #1;
            if (cyc == 0) chk("busy_after_start", 32'(o_busy), 32'd1);
            if (prev_stall) begin
                chk("stall_valid_hold", 32'(o_valid), 32'd1);
                chk("stall_data_hold", 32'(o_data), 32'(prev_data));
            end
            if (beat_idx >= nbeats) begin
                if (stop_after == 0) chk("extra_beat_refused", 32'(o_in_ready), 32'd0);
            end else if (in_valid_t && o_in_ready) begin
                beat_idx++;
                held = 1'b0;
            end
            if (o_valid && pos < padf.size() && padf[pos]) chk("in_ready_in_pad", 32'(o_in_ready), 32'd0);
            if (o_valid && out_ready_t) begin
                if (pos < expq.size()) begin
                    chk("out_byte", 32'(o_data), 32'(expq[pos]));
                    chk("out_last", 32'(o_last), 32'(pos == fsize - 1));
                end else begin
                    chk("byte_past_end", 32'(o_valid), 32'd0);
                end
                if (pos < 64) got[pos] = o_data;
                pos++;
            end
            prev_stall = o_valid && !out_ready_t;
            prev_data  = o_data;
            cyc++;
            if (pos == fsize) begin
                @(negedge clk); #1;
                chk("write_done_pulse", 32'(o_done), 32'd1);
                chk("busy_low_at_done", 32'(o_busy), 32'd0);
                @(negedge clk); #1;
                chk("write_done_single", 32'(o_done), 32'd0);
                chk("idle_no_valid", 32'(o_valid), 32'd0);
                finished = 1'b1;
            end else if (stop_after > 0 && pos >= stop_after) begin
                finished = 1'b1;
            end else if (cyc > MAX_CYC) begin
                n_tests++;
                n_fail++;
                $error("FAIL cycle_budget: observed %0d bytes expected %0d", pos, fsize);
                finished = 1'b1;
            end
            if (!finished) @(negedge clk);
        end
        start_t    = 1'b0;
        in_valid_t = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; sel = 0; start_t = 1'b0; in_valid_t = 1'b0;
        out_ready_t = 1'b0; in_data_t = '0;
        repeat (3) @(negedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = 32'(s);
            #1;
            chk_idle("reset_state");
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Default parameters: header bytes and PPB=2 pixel ordering, then abort mid-pixel.
        run_frame(0, 768, 512, 2, 1'b0, 60, 1'b1, 0, 100, 100);
        chk_bytes("hdr_dflt_0_5", 0, 64'h0000_424D_3600_1200, 6);
        chk_bytes("hdr_dflt_18_25", 18, 64'h0003_0000_0002_0000, 8);
        chk_bytes("hdr_dflt_34_37", 34, 64'h0000_0000_0000_1200, 4);
        chk_bytes("ppb2_order", 54, 64'h0000_CCBB_AA33_2211, 6);
        rst_n = 1'b0;
        #1;
        chk_idle("abort_mid_pixel");
        @(negedge clk);
        rst_n = 1'b1;

        // Small padded frame: abort in the header, then clean and back-pressured runs.
        run_frame(1, 5, 2, 1, 1'b0, 30, 1'b0, 0, 60, 60);
        rst_n = 1'b0;
        #1;
        chk_idle("abort_mid_header");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("no_done_after_abort", 32'(o_done), 32'd0);
        run_frame(1, 5, 2, 1, 1'b0, 0, 1'b0, 0, 100, 100);
        chk_bytes("hdr_pad_2_5", 2, 64'h0000_0000_5600_0000, 4);
        run_frame(1, 5, 2, 1, 1'b0, 0, 1'b0, 60, 50, 50);

        // Top-down header and long back-pressured frame with 2-byte row padding.
        run_frame(2, 6, 512, 2, 1'b1, 0, 1'b0, 70, 50, 70);
        chk_bytes("hdr_topdown_22_25", 22, 64'h0000_0000_00FE_FFFF, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
